// File: rtl/fir_mc.sv
// fir_mc: multi-channel serial FIR with one shared multiply-accumulate unit.
// Each channel keeps its own circular delay line. One coefficient bank is
// shared by all channels and is writable at runtime. Each result is rounded,
// shifted right by FRAC and then saturated to WIDTH bits.
//
// Handshake: a sample transfers on a rising edge where input_valid and
// input_ready are both high. input_ready depends only on the FSM state and
// never on input_valid. output_valid is a one-cycle pulse, with no back-pressure.
module fir_mc #(
  parameter int WIDTH      = 16,
  parameter int LENGTH     = 64,
  parameter int CHANNELS   = 4,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC       = 15,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW        = $clog2(LENGTH),
  localparam int ACC       = WIDTH + COEF_WIDTH + AW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      FIR_input,
  input  logic [CW-1:0]         input_channel,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic                  coef_wr,
  input  logic [AW-1:0]         coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic [WIDTH-1:0]      FIR_output,
  output logic [CW-1:0]         output_channel,
  output logic                  output_valid,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUTPUT = 2'd2} state_t;

  localparam logic signed [ACC:0] RND     = (ACC+1)'((64'd1 << FRAC) >> 1);
  localparam logic signed [ACC:0] SAT_MAX = {{(ACC+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC:0] SAT_MIN = ~SAT_MAX;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0]      line_mem [CHANNELS][LENGTH];
  logic        [AW-1:0]         wptr     [CHANNELS];
  logic signed [COEF_WIDTH-1:0] coef_mem [LENGTH];
  logic signed [ACC-1:0]        acc;
  logic        [AW-1:0]         k;
  logic        [CW-1:0]         ch_q;

  logic                            ch_ok, accept, coef_ok, last_tap;
  logic [AW:0]                     idx_sum, wptr_inc;
  logic [AW-1:0]                   rd_idx, wptr_next;
  logic signed [WIDTH+COEF_WIDTH-1:0] prod;
  logic signed [ACC-1:0]           prod_ext;
  logic signed [ACC:0]             rnd_sum, shifted;
  logic [WIDTH-1:0]                sat_val;

  assign ch_ok     = 32'(input_channel) < CHANNELS;
  assign accept    = (state_q == IDLE) && input_valid && ch_ok;
  assign coef_ok   = 32'(coef_addr) < LENGTH;
  assign last_tap  = (k == AW'(LENGTH - 1));
  assign dbg_state = state_q;

  // Tap address (wptr - k) mod LENGTH, kept in range for any LENGTH.
  always_comb begin
    idx_sum = {1'b0, wptr[ch_q]} + (AW+1)'(LENGTH) - {1'b0, k};
    if (idx_sum >= (AW+1)'(LENGTH)) idx_sum = idx_sum - (AW+1)'(LENGTH);
    rd_idx   = idx_sum[AW-1:0];
    wptr_inc = {1'b0, wptr[ch_q]} + 1'b1;
    wptr_next = (wptr_inc == (AW+1)'(LENGTH)) ? '0 : wptr_inc[AW-1:0];
  end

  // Full-precision product and round / shift / saturate of the accumulator.
  always_comb begin
    prod     = coef_mem[k] * line_mem[ch_q][rd_idx];
    prod_ext = prod;
    rnd_sum  = $signed({acc[ACC-1], acc}) + RND;
    shifted  = rnd_sum >>> FRAC;
    if (shifted > SAT_MAX)      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN) sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    else                        sat_val = shifted[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and Moore ready. An out-of-range channel is accepted but ignored.
  always_comb begin
    state_d     = state_q;
    input_ready = 1'b0;
    case (state_q)
      IDLE: begin
        input_ready = 1'b1;
        if (accept) state_d = ACCUM;
      end
      ACCUM:   if (last_tap) state_d = OUTPUT;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: delay lines, coefficients, accumulator and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < LENGTH; t++) line_mem[c][t] <= '0;
      end
      for (int t = 0; t < LENGTH; t++) coef_mem[t] <= '0;
      acc            <= '0;
      k              <= '0;
      ch_q           <= '0;
      FIR_output     <= '0;
      output_channel <= '0;
      output_valid   <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      // Coefficient writes land only in IDLE, so a running sum never sees a change.
      if (state_q == IDLE && coef_wr && coef_ok) coef_mem[coef_addr] <= coef_data;
      case (state_q)
        IDLE: begin
          if (accept) begin
            line_mem[input_channel][wptr[input_channel]] <= FIR_input;
            ch_q <= input_channel;
            acc  <= '0;
            k    <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + prod_ext;
          k   <= k + 1'b1;
        end
        OUTPUT: begin
          FIR_output     <= sat_val;
          output_channel <= ch_q;
          output_valid   <= 1'b1;
          wptr[ch_q]     <= wptr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mc.sv
// Directed bench for fir_mc. Two instances share all inputs: dut_a uses
// FRAC=0 for exact integer results, and dut_b uses FRAC=15 for rounding and
// saturation.
module tb_fir_mc;

  localparam int L  = 8;
  localparam int CH = 3;

  logic        clk, reset;
  logic [15:0] FIR_input;
  logic [1:0]  input_channel;
  logic        input_valid, coef_wr;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;

  logic        rdy_a, ov_a, rdy_b, ov_b;
  logic [15:0] out_a, out_b;
  logic [1:0]  och_a, och_b, st_a, st_b;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fir_mc #(.WIDTH(16), .LENGTH(L), .CHANNELS(CH), .COEF_WIDTH(16), .FRAC(0)) dut_a (
    .clk(clk), .reset(reset), .FIR_input(FIR_input), .input_channel(input_channel),
    .input_valid(input_valid), .input_ready(rdy_a), .coef_wr(coef_wr),
    .coef_addr(coef_addr), .coef_data(coef_data), .FIR_output(out_a),
    .output_channel(och_a), .output_valid(ov_a), .dbg_state(st_a));

  fir_mc #(.WIDTH(16), .LENGTH(L), .CHANNELS(CH), .COEF_WIDTH(16), .FRAC(15)) dut_b (
    .clk(clk), .reset(reset), .FIR_input(FIR_input), .input_channel(input_channel),
    .input_valid(input_valid), .input_ready(rdy_b), .coef_wr(coef_wr),
    .coef_addr(coef_addr), .coef_data(coef_data), .FIR_output(out_b),
    .output_channel(och_b), .output_valid(ov_b), .dbg_state(st_b));

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic apply_reset();
    reset = 1'b0; input_valid = 1'b0; coef_wr = 1'b0; FIR_input = '0;
    input_channel = '0; coef_addr = '0; coef_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string who);
    int g = 0;
    while (rdy_a !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) begin
      chk_cnt++;
      $display("FAIL %s_ready_timeout: input_ready stayed %b, required 1", who, rdy_a);
    end
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    wait_ready("coef");
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk);
    coef_wr = 1'b0;
  endtask

  // The task returns on the negedge just after the accepting edge.
  task automatic send_sample(input logic [1:0] ch, input logic [15:0] d);
    wait_ready("send");
    input_valid = 1'b1; input_channel = ch; FIR_input = d;
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  task automatic wait_result(input bit sel, input int bound, output logic [15:0] d,
                             output logic [1:0] c, output int lat);
    d = '0; c = '0; lat = -1;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if ((sel ? ov_b : ov_a) === 1'b1) begin
        d = sel ? out_b : out_a;
        c = sel ? och_b : och_a;
        lat = n;
        break;
      end
    end
  endtask

  // Scenario tasks.
  task automatic test_reset();
    reset = 1'b0; input_valid = 1'b0; coef_wr = 1'b0; FIR_input = '0;
    input_channel = '0; coef_addr = '0; coef_data = '0;
    #12;
    chk_cnt++; if (ov_a !== 1'b0) $display("FAIL reset_valid: got %b, required 0", ov_a); else pass_cnt++;
    chk_cnt++; if (out_a !== 16'h0) $display("FAIL reset_output: got %h, required 0000", out_a); else pass_cnt++;
    chk_cnt++; if (och_a !== 2'd0) $display("FAIL reset_channel: got %0d, required 0", och_a); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++; if (rdy_a !== 1'b1) $display("FAIL reset_ready: got %b, required 1", rdy_a); else pass_cnt++;
    chk_cnt++; if (st_a !== 2'd0) $display("FAIL reset_state: got %0d, required 0", st_a); else pass_cnt++;
  endtask

  task automatic test_impulse();
    logic [15:0] d; logic [1:0] c; int lat;
    apply_reset();
    for (int t = 0; t < L; t++) write_coef(3'(t), 16'(t + 1));
    for (int j = 0; j < L; j++) begin
      send_sample(2'd0, (j == 0) ? 16'd1 : 16'd0);
      wait_result(1'b0, 20, d, c, lat);
      chk_cnt++; if (d !== 16'(j + 1)) $display("FAIL impulse_data[%0d]: got %0d, required %0d", j, d, j + 1); else pass_cnt++;
      chk_cnt++; if (c !== 2'd0) $display("FAIL impulse_chan[%0d]: got %0d, required 0", j, c); else pass_cnt++;
      chk_cnt++; if (lat !== L + 1) $display("FAIL impulse_latency[%0d]: got %0d, required %0d", j, lat, L + 1); else pass_cnt++;
    end
  endtask

  task automatic test_isolation();
    logic [15:0] d; logic [1:0] c; int lat;
    logic [1:0]  chs  [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    logic [15:0] ins  [5] = '{16'd100, 16'hFFCE, 16'd0, 16'd0, 16'd0};
    logic [15:0] exps [5] = '{16'd100, 16'hFFCE, 16'd200, 16'hFF9C, 16'd0};
    apply_reset();
    write_coef(3'd0, 16'd1);
    write_coef(3'd1, 16'd2);
    for (int i = 0; i < 5; i++) begin
      send_sample(chs[i], ins[i]);
      wait_result(1'b0, 20, d, c, lat);
      chk_cnt++; if (d !== exps[i]) $display("FAIL isolation_data[%0d]: got %h, required %h", i, d, exps[i]); else pass_cnt++;
      chk_cnt++; if (c !== chs[i]) $display("FAIL isolation_chan[%0d]: got %0d, required %0d", i, c, chs[i]); else pass_cnt++;
    end
  endtask

  task automatic test_coef_gating();
    logic [15:0] d; logic [1:0] c; int lat;
    apply_reset();
    write_coef(3'd0, 16'd5);
    send_sample(2'd0, 16'd1);
    coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 16'd9;
    @(negedge clk);
    coef_wr = 1'b0;
    wait_result(1'b0, 20, d, c, lat);
    chk_cnt++; if (d !== 16'd5) $display("FAIL gating_busy_write: got %0d, required 5", d); else pass_cnt++;
    send_sample(2'd1, 16'd1);
    wait_result(1'b0, 20, d, c, lat);
    chk_cnt++; if (d !== 16'd5) $display("FAIL gating_readback: got %0d, required 5", d); else pass_cnt++;
    wait_ready("gating");
    coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 16'd7;
    input_valid = 1'b1; input_channel = 2'd1; FIR_input = 16'd1;
    @(negedge clk);
    coef_wr = 1'b0; input_valid = 1'b0;
    wait_result(1'b0, 20, d, c, lat);
    chk_cnt++; if (d !== 16'd7) $display("FAIL gating_same_cycle: got %0d, required 7", d); else pass_cnt++;
    chk_cnt++; if (lat !== L + 1) $display("FAIL gating_latency: got %0d, required %0d", lat, L + 1); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [15:0] d; logic [1:0] c; int lat;
    apply_reset();
    write_coef(3'd0, 16'd1);
    send_sample(2'd3, 16'd77);
    chk_cnt++; if (rdy_a !== 1'b1) $display("FAIL oor_ready: got %b, required 1", rdy_a); else pass_cnt++;
    chk_cnt++; if (st_a !== 2'd0) $display("FAIL oor_state: got %0d, required 0", st_a); else pass_cnt++;
    wait_result(1'b0, 15, d, c, lat);
    chk_cnt++; if (lat !== -1) $display("FAIL oor_no_output: got valid at cycle %0d, required none", lat); else pass_cnt++;
    send_sample(2'd2, 16'd5);
    wait_result(1'b0, 20, d, c, lat);
    chk_cnt++; if (d !== 16'd5) $display("FAIL oor_next_data: got %0d, required 5", d); else pass_cnt++;
    chk_cnt++; if (c !== 2'd2) $display("FAIL oor_next_chan: got %0d, required 2", c); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic [1:0] c; int lat;
    logic exp_rdy, exp_ov;
    apply_reset();
    write_coef(3'd0, 16'd1);
    input_valid = 1'b1; input_channel = 2'd0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      exp_rdy = (n % 10 == 0);
      exp_ov  = (n % 10 == 0) && (n > 0);
      chk_cnt++; if (rdy_a !== exp_rdy) $display("FAIL b2b_ready[%0d]: got %b, required %b", n, rdy_a, exp_rdy); else pass_cnt++;
      chk_cnt++; if (ov_a !== exp_ov) $display("FAIL b2b_valid[%0d]: got %b, required %b", n, ov_a, exp_ov); else pass_cnt++;
      if (exp_ov) begin
        chk_cnt++; if (out_a !== 16'(11 * (n / 10))) $display("FAIL b2b_data[%0d]: got %0d, required %0d", n, out_a, 11 * (n / 10)); else pass_cnt++;
      end
      if (n % 10 == 0) FIR_input = 16'(11 * (n / 10 + 1));
    end
    input_valid = 1'b0;
    wait_result(1'b0, 15, d, c, lat);
    chk_cnt++; if (d !== 16'd44) $display("FAIL b2b_last: got %0d, required 44", d); else pass_cnt++;
  endtask

  task automatic test_rounding();
    logic [15:0] d; logic [1:0] c; int lat;
    apply_reset();
    write_coef(3'd0, 16'h7FFF);
    send_sample(2'd0, 16'h7FFF);
    wait_result(1'b1, 20, d, c, lat);
    chk_cnt++; if (d !== 16'h7FFE) $display("FAIL round_single: got %h, required 7ffe", d); else pass_cnt++;
    apply_reset();
    write_coef(3'd0, 16'h7FFF);
    write_coef(3'd1, 16'h7FFF);
    send_sample(2'd0, 16'h7FFF);
    wait_result(1'b1, 20, d, c, lat);
    chk_cnt++; if (d !== 16'h7FFE) $display("FAIL round_pos_first: got %h, required 7ffe", d); else pass_cnt++;
    send_sample(2'd0, 16'h7FFF);
    wait_result(1'b1, 20, d, c, lat);
    chk_cnt++; if (d !== 16'h7FFF) $display("FAIL sat_pos: got %h, required 7fff", d); else pass_cnt++;
    apply_reset();
    write_coef(3'd0, 16'h7FFF);
    write_coef(3'd1, 16'h7FFF);
    send_sample(2'd0, 16'h8000);
    wait_result(1'b1, 20, d, c, lat);
    chk_cnt++; if (d !== 16'h8001) $display("FAIL round_neg_first: got %h, required 8001", d); else pass_cnt++;
    send_sample(2'd0, 16'h8000);
    wait_result(1'b1, 20, d, c, lat);
    chk_cnt++; if (d !== 16'h8000) $display("FAIL sat_neg: got %h, required 8000", d); else pass_cnt++;
  endtask

  task automatic test_reset_mid_accum();
    logic [15:0] d; logic [1:0] c; int lat;
    write_coef(3'd0, 16'd3);
    send_sample(2'd0, 16'd4);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk_cnt++; if (ov_a !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", ov_a); else pass_cnt++;
    chk_cnt++; if (out_a !== 16'h0) $display("FAIL midrst_output_a: got %h, required 0000", out_a); else pass_cnt++;
    chk_cnt++; if (out_b !== 16'h0) $display("FAIL midrst_output_b: got %h, required 0000", out_b); else pass_cnt++;
    chk_cnt++; if (och_a !== 2'd0) $display("FAIL midrst_channel: got %0d, required 0", och_a); else pass_cnt++;
    chk_cnt++; if (st_a !== 2'd0) $display("FAIL midrst_state: got %0d, required 0", st_a); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    wait_result(1'b0, 15, d, c, lat);
    chk_cnt++; if (lat !== -1) $display("FAIL midrst_no_output: got valid at cycle %0d, required none", lat); else pass_cnt++;
    send_sample(2'd0, 16'd4);
    wait_result(1'b0, 20, d, c, lat);
    chk_cnt++; if (d !== 16'd0) $display("FAIL midrst_after: got %0d, required 0", d); else pass_cnt++;
    chk_cnt++; if (lat !== L + 1) $display("FAIL midrst_latency: got %0d, required %0d", lat, L + 1); else pass_cnt++;
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_impulse();
    test_isolation();
    test_coef_gating();
    test_out_of_range();
    test_back_to_back();
    test_rounding();
    test_reset_mid_accum();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
